// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display paths: digit patterns (active-low, gfedcba),
// converter sizing, FSM state type and the reverse double-dabble step.
package seg7_pkg;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned DIGITS = 3;
  localparam int unsigned BIN_W  = 8;
  localparam int unsigned ITER   = 8;
  localparam int unsigned SR_W   = DIGITS * 4 + BIN_W;
  localparam int unsigned CNT_W  = $clog2(ITER);

  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StShift,
    StDone
  } state_e;

  // One reverse double-dabble iteration: shift right, then pull any nibble >= 8 down by 3.
  function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
    logic [SR_W-1:0] s;
    s = sr >> 1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (s[BIN_W + 4*i + 3]) begin
        s[BIN_W + 4*i +: 4] = s[BIN_W + 4*i +: 4] - 4'd3;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/seg7_to_binary_if.sv
// Request/result bundle of the segment-to-binary converter.
interface seg7_to_binary_if;
  import seg7_pkg::*;

  logic             start;
  logic [SEG_W-1:0] seg_h;
  logic [SEG_W-1:0] seg_t;
  logic [SEG_W-1:0] seg_o;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] value;
  logic             err_seg;
  logic             err_ovf;

  modport master (
    output start, seg_h, seg_t, seg_o,
    input  busy, done, value, err_seg, err_ovf
  );

  modport slave (
    input  start, seg_h, seg_t, seg_o,
    output busy, done, value, err_seg, err_ovf
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational decode of one 7-segment pattern back to a BCD digit with a legality flag.
module seg7_decode import seg7_pkg::*; #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_AS_ZERO = 1'b0
) (
  input  logic [SEG_W-1:0] seg_i,
  output logic [3:0]       digit_o,
  output logic             valid_o
);

  logic [SEG_W-1:0] pat;

  always_comb begin
    pat     = ACTIVE_LOW ? seg_i : ~seg_i;
    digit_o = 4'd0;
    valid_o = 1'b1;
    case (pat)
      SEG_0:     digit_o = 4'd0;
      SEG_1:     digit_o = 4'd1;
      SEG_2:     digit_o = 4'd2;
      SEG_3:     digit_o = 4'd3;
      SEG_4:     digit_o = 4'd4;
      SEG_5:     digit_o = 4'd5;
      SEG_6:     digit_o = 4'd6;
      SEG_7:     digit_o = 4'd7;
      SEG_8:     digit_o = 4'd8;
      SEG_9:     digit_o = 4'd9;
      // Leading-zero blanking shows an unlit digit where a 0 would be.
      SEG_BLANK: valid_o = BLANK_AS_ZERO;
      default:   valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_to_binary.sv
// Recovers the displayed byte from three 7-segment patterns: decode to BCD, then
// reverse double-dabble over ITER cycles, with sticky invalid/overflow status.
module seg7_to_binary import seg7_pkg::*; #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter bit BLANK_AS_ZERO = 1'b0
) (
  input logic              clk,
  input logic              rst,
  seg7_to_binary_if.slave  bus
);

  logic [3:0] dig_h, dig_t, dig_o;
  logic       ok_h, ok_t, ok_o;

  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW), .BLANK_AS_ZERO(BLANK_AS_ZERO)) u_dec_h (
    .seg_i   (bus.seg_h),
    .digit_o (dig_h),
    .valid_o (ok_h)
  );

  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW), .BLANK_AS_ZERO(BLANK_AS_ZERO)) u_dec_t (
    .seg_i   (bus.seg_t),
    .digit_o (dig_t),
    .valid_o (ok_t)
  );

  seg7_decode #(.ACTIVE_LOW(ACTIVE_LOW), .BLANK_AS_ZERO(BLANK_AS_ZERO)) u_dec_o (
    .seg_i   (bus.seg_o),
    .digit_o (dig_o),
    .valid_o (ok_o)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d, sr_step;
  logic             seg_ok_q, seg_ok_d;
  logic [BIN_W-1:0] value_q, value_d;
  logic             err_seg_q, err_seg_d;
  logic             err_ovf_q, err_ovf_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    seg_ok_d  = seg_ok_q;
    value_d   = value_q;
    err_seg_d = err_seg_q;
    err_ovf_d = err_ovf_q;
    sr_step   = dabble_step(sr_q);

    unique case (state_q)
      StIdle: begin
        // Patterns are decoded and frozen here; later seg_* changes cannot leak in.
        if (bus.start) begin
          sr_d      = {dig_h, dig_t, dig_o, {BIN_W{1'b0}}};
          seg_ok_d  = ok_h & ok_t & ok_o;
          value_d   = '0;
          err_seg_d = 1'b0;
          err_ovf_d = 1'b0;
          state_d   = StLoad;
        end
      end
      StLoad: begin
        if (seg_ok_q) begin
          cnt_d   = '0;
          state_d = StShift;
        end else begin
          err_seg_d = 1'b1;
          state_d   = StDone;
        end
      end
      StShift: begin
        sr_d  = sr_step;
        cnt_d = cnt_q + 1'b1;
        // Result is registered with the final shift so it is valid alongside done.
        if (cnt_q == CNT_W'(ITER - 1)) begin
          state_d = StDone;
          if (sr_step[SR_W-1:BIN_W] != '0) begin
            err_ovf_d = 1'b1;
          end else begin
            value_d = sr_step[BIN_W-1:0];
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sr_q      <= '0;
      seg_ok_q  <= 1'b0;
      value_q   <= '0;
      err_seg_q <= 1'b0;
      err_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      seg_ok_q  <= seg_ok_d;
      value_q   <= value_d;
      err_seg_q <= err_seg_d;
      err_ovf_q <= err_ovf_d;
    end
  end

  assign bus.busy    = (state_q == StLoad) || (state_q == StShift);
  assign bus.done    = (state_q == StDone);
  assign bus.value   = value_q;
  assign bus.err_seg = err_seg_q;
  assign bus.err_ovf = err_ovf_q;

endmodule
